// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked ALU between two requesters.
// Ports: clk/rst_n, r0_*/r1_* request side, alu_* ALU side, rsp_* result side, busy.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [1:0]       r0_op,
    input  logic             r0_sel,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [1:0]       r1_op,
    input  logic             r1_sel,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    output logic [1:0]       alu_op,
    output logic             alu_mux_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] mux_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_alu,
    output logic [WIDTH-1:0] rsp_mux,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_sel;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_alu;
    logic [WIDTH-1:0] r_rsp_mux;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;

    // Grants exist only in IDLE; on a tie the requester that did not
    // win last time is served.
    always_comb begin
        w_next = r_state;
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_gnt0 = r0_valid && (!r1_valid || r_last);
                w_gnt1 = r1_valid && (!r0_valid || !r_last);
                if (w_gnt0 || w_gnt1)
                    w_next = EXEC;
            end
            EXEC: begin
                if (r_cnt == 4'd0)
                    w_next = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = w_gnt0 || w_gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 2'd0;
            r_sel       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_alu   <= '0;
            r_rsp_mux   <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= w_gnt1 ? r1_a   : r0_a;
                r_b      <= w_gnt1 ? r1_b   : r0_b;
                r_op     <= w_gnt1 ? r1_op  : r0_op;
                r_sel    <= w_gnt1 ? r1_sel : r0_sel;
                r_last   <= w_gnt1;
                r_rsp_id <= w_gnt1;
                r_cnt    <= 4'(ALU_LAT);
            end
            if (r_state == EXEC) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_rsp_alu   <= alu_out;
                    r_rsp_mux   <= mux_out;
                    r_rsp_valid <= 1'b1;
                end
            end
            if (r_state == RESP && rsp_ready)
                r_rsp_valid <= 1'b0;
        end
    end

    assign r0_ready    = w_gnt0;
    assign r1_ready    = w_gnt1;
    assign alu_in_a    = r_a;
    assign alu_in_b    = r_b;
    assign alu_op      = r_op;
    assign alu_mux_sel = r_sel;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_alu     = r_rsp_alu;
    assign rsp_mux     = r_rsp_mux;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a 1-cycle ALU stub.
// Two instances: ALU_LAT=1 (main) and ALU_LAT=3.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    int          n_cmp;
    int          n_bad;

    logic        r0_valid, r0_ready, r0_sel;
    logic        r1_valid, r1_ready, r1_sel;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [1:0]  r0_op, r1_op;
    logic [31:0] alu_in_a, alu_in_b, alu_out, mux_out;
    logic [1:0]  alu_op;
    logic        alu_mux_sel;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_alu, rsp_mux;

    logic        q0_ready;
    logic        q1_valid, q1_ready;
    logic [31:0] q_in_a, q_in_b, q_alu_out, q_mux_out;
    logic [1:0]  q_op;
    logic        q_sel;
    logic        q_rsp_valid, q_rsp_ready, q_rsp_id, q_busy;
    logic [31:0] q_rsp_alu, q_rsp_mux;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, b,
                                          input logic [1:0] op);
        case (op)
            2'b01:   return a + b;
            2'b10:   return a & b;
            2'b11:   return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) alu_out   <= alu_f(alu_in_a, alu_in_b, alu_op);
    always_ff @(posedge clk) q_alu_out <= alu_f(q_in_a, q_in_b, q_op);
    assign mux_out   = alu_mux_sel ? alu_in_b : alu_in_a;
    assign q_mux_out = q_sel ? q_in_b : q_in_a;

    alu_arbiter #(.WIDTH(32), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_sel(r0_sel),
        .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_sel(r1_sel),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_op(alu_op), .alu_mux_sel(alu_mux_sel),
        .alu_out(alu_out), .mux_out(mux_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_alu(rsp_alu), .rsp_mux(rsp_mux), .busy(busy)
    );

    alu_arbiter #(.WIDTH(32), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(1'b0), .r0_ready(q0_ready),
        .r0_a(32'd0), .r0_b(32'd0), .r0_op(2'd0), .r0_sel(1'b0),
        .r1_valid(q1_valid), .r1_ready(q1_ready),
        .r1_a(32'h5), .r1_b(32'h6), .r1_op(2'b01), .r1_sel(1'b1),
        .alu_in_a(q_in_a), .alu_in_b(q_in_b),
        .alu_op(q_op), .alu_mux_sel(q_sel),
        .alu_out(q_alu_out), .mux_out(q_mux_out),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id),
        .rsp_alu(q_rsp_alu), .rsp_mux(q_rsp_mux), .busy(q_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Waits for a grant, checks it, drives the operation to completion
    // with rsp_ready held low for 'hold' cycles, then handshakes.
    task automatic do_txn(input logic eid, input logic [31:0] ealu,
                          input logic [31:0] emux, input bit drop,
                          input int hold);
        int n;
        #1;
        n = 0;
        while (!(r0_ready || r1_ready) && n < 20) begin
            step();
            n++;
        end
        check("grant_seen", {31'd0, r0_ready || r1_ready}, 32'd1);
        check("grant_id", {31'd0, r1_ready}, {31'd0, eid});
        check("grant_excl", {31'd0, r0_ready && r1_ready}, 32'd0);
        step();
        if (drop) begin
            if (eid) r1_valid = 1'b0;
            else     r0_valid = 1'b0;
        end
        check("busy_exec", {31'd0, busy}, 32'd1);
        check("no_ready_exec", {31'd0, r0_ready || r1_ready}, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("latency", n, 32'd2);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, eid});
        check("rsp_alu", rsp_alu, ealu);
        check("rsp_mux", rsp_mux, emux);
        for (int k = 0; k < hold; k++) begin
            step();
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_alu", rsp_alu, ealu);
            check("hold_mux", rsp_mux, emux);
            check("hold_no_ready", {31'd0, r0_ready || r1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int g0;
        int g1;
        int n;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0; r0_sel = 1'b0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0; r1_sel = 1'b0;
        rsp_ready = 1'b0;
        q1_valid = 1'b0;
        q_rsp_ready = 1'b0;
        step();
        step();

        check("rst_alu_a", alu_in_a, 32'd0);
        check("rst_alu_b", alu_in_b, 32'd0);
        check("rst_op", {30'd0, alu_op}, 32'd0);
        check("rst_sel", {31'd0, alu_mux_sel}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_alu", rsp_alu, 32'd0);
        check("rst_rsp_mux", rsp_mux, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single op from r0
        r0_a = 32'hFFFF; r0_b = 32'hC23A; r0_op = 2'b01; r0_sel = 1'b0;
        r0_valid = 1'b1;
        do_txn(1'b0, 32'h0001C239, 32'h0000FFFF, 1'b1, 0);
        check("inputs_kept", alu_in_a, 32'h0000FFFF);

        // 2: simultaneous after reset -> r0 first, then r1
        pulse_reset();
        r0_a = 32'h1234; r0_b = 32'h1111; r0_op = 2'b01; r0_sel = 1'b0;
        r1_a = 32'hAB12; r1_b = 32'h12BA; r1_op = 2'b10; r1_sel = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        do_txn(1'b0, 32'h2345, 32'h1234, 1'b1, 0);
        do_txn(1'b1, 32'h0212, 32'h12BA, 1'b1, 0);

        // 3: both held valid for 6 ops -> strict alternation
        r0_a = 32'h1;  r0_b = 32'h2;  r0_op = 2'b01; r0_sel = 1'b1;
        r1_a = 32'hF0; r1_b = 32'h3C; r1_op = 2'b11; r1_sel = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        g0 = 0;
        g1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                do_txn(1'b0, 32'h3, 32'h2, i >= 4, 0);
                g0++;
            end else begin
                do_txn(1'b1, 32'hCC, 32'hF0, i >= 4, 0);
                g1++;
            end
        end
        check("g0_count", g0, 32'd3);
        check("g1_count", g1, 32'd3);
        check("valids_done", {31'd0, r0_ready || r1_ready}, 32'd0);

        // 4: rsp_ready held off while r1 waits
        r0_a = 32'h12C5; r0_b = 32'hD145; r0_op = 2'b11; r0_sel = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        do_txn(1'b0, 32'hC380, 32'hD145, 1'b1, 5);
        do_txn(1'b1, 32'hCC, 32'hF0, 1'b1, 0);

        // 5: async reset during EXEC aborts the op
        r0_a = 32'h10; r0_b = 32'h20; r0_op = 2'b01; r0_sel = 1'b0;
        r0_valid = 1'b1;
        #1;
        check("t5_grant", {31'd0, r0_ready}, 32'd1);
        step();
        r0_valid = 1'b0;
        step();
        check("t5_in_exec", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_alu_a", alu_in_a, 32'd0);
        check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        r0_a = 32'h7; r0_b = 32'h8; r0_op = 2'b01; r0_sel = 1'b1;
        r0_valid = 1'b1;
        do_txn(1'b0, 32'hF, 32'h8, 1'b1, 0);

        // 6: ALU_LAT=3 instance, r1 alone
        q1_valid = 1'b1;
        #1;
        check("q_grant", {31'd0, q1_ready}, 32'd1);
        check("q_grant0", {31'd0, q0_ready}, 32'd0);
        step();
        q1_valid = 1'b0;
        n = 0;
        while (!q_rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("q_latency", n, 32'd4);
        check("q_rsp_id", {31'd0, q_rsp_id}, 32'd1);
        check("q_rsp_alu", q_rsp_alu, 32'hB);
        check("q_rsp_mux", q_rsp_mux, 32'h6);
        q_rsp_ready = 1'b1;
        step();
        q_rsp_ready = 1'b0;
        check("q_rsp_drop", {31'd0, q_rsp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
